// File: rtl/smd_button_link_rx_pkg.sv
// Shared constants, button bit indices and FSM encoding for the MCU->smdsixbutton serial link.
package smd_link_pkg;

  localparam int          FRAME_BITS = 16;
  localparam logic [3:0]  HEADER     = 4'hA;
  localparam logic [4:0]  CNT_SAT    = 5'd17;

  // Frame bit index of each button; frame[11] is sent first of the button field.
  localparam int BTN_UP = 11;
  localparam int BTN_DW = 10;
  localparam int BTN_LF = 9;
  localparam int BTN_RG = 8;
  localparam int BTN_A  = 7;
  localparam int BTN_B  = 6;
  localparam int BTN_C  = 5;
  localparam int BTN_ST = 4;
  localparam int BTN_X  = 3;
  localparam int BTN_Y  = 2;
  localparam int BTN_Z  = 1;
  localparam int BTN_MD = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } link_state_t;

  function automatic logic frame_valid(input logic [4:0] cnt, input logic [15:0] sr);
    return (cnt == 5'(FRAME_BITS)) && (sr[15:12] == HEADER);
  endfunction

endpackage

// File: rtl/smd_button_link_rx_if.sv
// Link-side bundle: SPI pins from the MCU plus the button lines and status pulses toward smdsixbutton.
interface smd_button_link_rx_if;
  import smd_link_pkg::*;

  // No valid/ready here: spi_* are free-running pins sampled through synchronizers,
  // frame_ok/link_err are single-clk pulses, buttons are levels that change only on frame_ok
  // (or on watchdog expiry, flagged by link_lost).
  logic spi_ss_n;
  logic spi_sck;
  logic spi_mosi;
  logic up, dw, lf, rg, a, b, c, st, x, y, z, md;
  logic frame_ok;
  logic link_err;
  logic link_lost;
  link_state_t dbg_state;

  modport master (
    output spi_ss_n, spi_sck, spi_mosi,
    input  up, dw, lf, rg, a, b, c, st, x, y, z, md,
    input  frame_ok, link_err, link_lost, dbg_state
  );

  modport slave (
    input  spi_ss_n, spi_sck, spi_mosi,
    output up, dw, lf, rg, a, b, c, st, x, y, z, md,
    output frame_ok, link_err, link_lost, dbg_state
  );

endinterface

// File: rtl/smd_button_link_rx_sync_edge.sv
// 2-FF synchronizer with rise/fall pulses derived from the synchronized copy.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/smd_button_link_rx.sv
// Serial frame receiver driving the 12 active-low smdsixbutton lines.
// Optional link watchdog built when LINK_WATCHDOG_EN is defined.
module smd_button_link_rx
  import smd_link_pkg::*;
#(
  parameter int WDOG_CYCLES = 2_000_000
) (
  input logic clk,
  input logic rst,
  smd_button_link_rx_if.slave bus
);

  logic ss_q, ss_rise, ss_fall_unused;
  logic sck_q_unused, sck_rise, sck_fall_unused;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d(bus.spi_ss_n),
    .q(ss_q), .rise(ss_rise), .fall(ss_fall_unused)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d(bus.spi_sck),
    .q(sck_q_unused), .rise(sck_rise), .fall(sck_fall_unused)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(bus.spi_mosi),
    .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  link_state_t state;
  logic [15:0] sr;
  logic [4:0]  cnt;
  logic [11:0] btn_q;
  logic        frame_ok_q;
  logic        link_err_q;
  logic        commit;
  logic        wd_expire;

  assign commit = (state == CHECK) && frame_valid(cnt, sr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      btn_q      <= '1;
      frame_ok_q <= 1'b0;
      link_err_q <= 1'b0;
    end else begin
      frame_ok_q <= 1'b0;
      link_err_q <= 1'b0;
      case (state)
        // Level test so a select that dropped while in CHECK still starts a frame here.
        IDLE: begin
          if (!ss_q) begin
            state <= SHIFT;
            sr    <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            sr <= {sr[14:0], mosi_q};
            if (cnt != CNT_SAT) cnt <= cnt + 5'd1;
          end
          if (ss_rise) state <= CHECK;
        end
        CHECK: begin
          if (commit) begin
            btn_q      <= sr[11:0];
            frame_ok_q <= 1'b1;
          end else begin
            link_err_q <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (wd_expire && !commit) btn_q <= '1;
    end
  end

`ifdef LINK_WATCHDOG_EN
  localparam int WDW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(WDOG_CYCLES - 1);

  logic [WDW-1:0] wd_cnt;
  logic           link_lost_q;

  assign wd_expire = (wd_cnt == WD_LAST);

  // Counter parks at its terminal value; only a committed frame restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      link_lost_q <= 1'b0;
    end else if (commit) begin
      wd_cnt      <= '0;
      link_lost_q <= 1'b0;
    end else if (wd_expire) begin
      link_lost_q <= 1'b1;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign bus.link_lost = link_lost_q;
`else
  logic wdog_cfg_unused;
  assign wdog_cfg_unused = ^WDOG_CYCLES;
  assign wd_expire       = 1'b0;
  assign bus.link_lost   = 1'b0;
`endif

  assign bus.up = btn_q[BTN_UP];
  assign bus.dw = btn_q[BTN_DW];
  assign bus.lf = btn_q[BTN_LF];
  assign bus.rg = btn_q[BTN_RG];
  assign bus.a  = btn_q[BTN_A];
  assign bus.b  = btn_q[BTN_B];
  assign bus.c  = btn_q[BTN_C];
  assign bus.st = btn_q[BTN_ST];
  assign bus.x  = btn_q[BTN_X];
  assign bus.y  = btn_q[BTN_Y];
  assign bus.z  = btn_q[BTN_Z];
  assign bus.md = btn_q[BTN_MD];

  assign bus.frame_ok  = frame_ok_q;
  assign bus.link_err  = link_err_q;
  assign bus.dbg_state = state;

endmodule
